// File: rtl/digit_to_binary.sv
// ---------------------------------------------------------------------------
// digit_to_binary
// Converts six captured BCD digits into a 20-bit binary value using a
// sequential reverse double-dabble (one shift/correct step per clock).
//
// Ports
//   clk                      rising-edge clock
//   reset                    synchronous, active-high reset
//   start                    conversion request, honoured only in IDLE
//   ones .. hundred_thousands BCD digits, sampled on the accepted start edge
//   q                        binary result (20 bits)
//   busy                     high while a conversion is running
//   done                     one-cycle pulse: q, ovf, err are valid
//   ovf                      result >= 2**LIMIT_W
//   err                      a captured digit was greater than 9
// ---------------------------------------------------------------------------
module digit_to_binary #(
    parameter int unsigned LIMIT_W = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  ones,
    input  logic [3:0]  tens,
    input  logic [3:0]  hundreds,
    input  logic [3:0]  thousands,
    input  logic [3:0]  ten_thousands,
    input  logic [3:0]  hundred_thousands,
    output logic [19:0] q,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        err
);

    localparam int unsigned BIN_W   = 20;
    localparam int unsigned NDIG    = 6;
    localparam int unsigned BCD_W   = 4 * NDIG;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned STEPS   = BIN_W;

    // A limit at or beyond the register width can never be reached.
    localparam bit               HAS_LIMIT = (LIMIT_W < BIN_W);
    localparam logic [BIN_W-1:0] LIMIT_VAL = HAS_LIMIT ? BIN_W'(1 << LIMIT_W) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd;
    logic [BIN_W-1:0]   bin;
    logic [CNT_W-1:0]   cnt;

    logic [BCD_W-1:0]   digits_c;
    logic               bad_c;
    logic [BCD_W-1:0]   shift_bcd_c;
    logic [BIN_W-1:0]   shift_bin_c;
    logic [BCD_W-1:0]   step_bcd_c;

    assign digits_c = {hundred_thousands, ten_thousands, thousands,
                       hundreds, tens, ones};

    // Any nibble above 9 makes the capture invalid.
    always_comb begin
        bad_c = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digits_c[4*i +: 4] > 4'd9) begin
                bad_c = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then pull every nibble
    // that landed at 8 or above back into BCD range by subtracting 3.
    always_comb begin
        {shift_bcd_c, shift_bin_c} = {bcd, bin} >> 1;
        step_bcd_c = shift_bcd_c;
        for (int i = 0; i < NDIG; i++) begin
            if (shift_bcd_c[4*i +: 4] >= 4'd8) begin
                step_bcd_c[4*i +: 4] = shift_bcd_c[4*i +: 4] - 4'd3;
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bcd   <= '0;
            bin   <= '0;
            cnt   <= '0;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bcd  <= digits_c;
                        bin  <= '0;
                        cnt  <= '0;
                        ovf  <= 1'b0;
                        err  <= bad_c;
                        // Invalid digits skip the conversion entirely.
                        busy  <= ~bad_c;
                        state <= bad_c ? DONE : CONV;
                    end
                end
                CONV: begin
                    bcd <= step_bcd_c;
                    bin <= shift_bin_c;
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    q     <= bin;
                    ovf   <= HAS_LIMIT && !err && (bin >= LIMIT_VAL);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_to_binary.sv
module tb_digit_to_binary;

    localparam int unsigned LW    = 17;
    localparam int          LIMIT = 1 << LW;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] dig;
    logic [19:0] q;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        err;

    int total;
    int bad;

    digit_to_binary #(.LIMIT_W(LW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .ones              (dig[3:0]),
        .tens              (dig[7:4]),
        .hundreds          (dig[11:8]),
        .thousands         (dig[15:12]),
        .ten_thousands     (dig[19:16]),
        .hundred_thousands (dig[23:20]),
        .q                 (q),
        .busy              (busy),
        .done              (done),
        .ovf               (ovf),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal value of the digit word, most significant digit first.
    function automatic int ref_value(input logic [23:0] dg);
        int v = 0;
        for (int i = 5; i >= 0; i--) begin
            v = v * 10 + int'(dg[4*i +: 4]);
        end
        return v;
    endfunction

    function automatic bit ref_bad(input logic [23:0] dg);
        for (int i = 0; i < 6; i++) begin
            if (dg[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [23:0] rand_digits(input bit allow_bad);
        logic [23:0] r;
        for (int i = 0; i < 6; i++) begin
            if (allow_bad && ($urandom % 10 == 0))
                r[4*i +: 4] = 4'($urandom_range(10, 15));
            else
                r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Full conversion with timing, pulse and hold checks.
    task automatic run_conv(input logic [23:0] dg, input bit mid_start);
        bit  e_bad;
        int  e_q;
        bit  e_ovf;
        int  n;
        int  busy_cnt;
        e_bad = ref_bad(dg);
        e_q   = e_bad ? 0 : ref_value(dg);
        e_ovf = !e_bad && (e_q >= LIMIT);

        dig   = dg;
        start = 1'b1;
        tick();
        start = 1'b0;
        dig   = 24'($urandom);
        check("busy_after_start", 32'(busy), 32'(!e_bad));
        check("err_at_capture", 32'(err), 32'(e_bad));
        check("ovf_cleared", 32'(ovf), 32'(0));

        n = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            if (mid_start && n == 4) begin
                start = 1'b1;
                dig   = rand_digits(1'b0);
            end
            tick();
            start = 1'b0;
            n++;
        end
        check("latency", 32'(n), e_bad ? 32'(1) : 32'(21));
        check("busy_cycles", 32'(busy_cnt), e_bad ? 32'(0) : 32'(21));
        check("q", 32'(q), 32'(e_q));
        check("ovf", 32'(ovf), 32'(e_ovf));
        check("err", 32'(err), 32'(e_bad));
        check("busy_at_done", 32'(busy), 32'(0));

        tick();
        check("done_single", 32'(done), 32'(0));
        tick();
        check("q_hold", 32'(q), 32'(e_q));
        check("err_hold", 32'(err), 32'(e_bad));
        check("ovf_hold", 32'(ovf), 32'(e_ovf));
    endtask

    initial begin
        int seen_done;
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        dig   = '0;
        tick();
        tick();
        check("rst_q", 32'(q), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        reset = 1'b0;
        tick();

        // Directed boundary cases.
        run_conv(24'h131071, 1'b0);
        run_conv(24'h131072, 1'b0);
        run_conv(24'h999999, 1'b0);
        run_conv(24'h000000, 1'b0);
        run_conv(24'h00000A, 1'b0);
        run_conv(24'h123456, 1'b0);
        run_conv(24'hF00000, 1'b0);
        run_conv(24'h654321, 1'b1);

        // Reset wins over start on the same edge.
        reset = 1'b1;
        start = 1'b1;
        dig   = 24'h000123;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_vs_start_busy", 32'(busy), 32'(0));
        tick();
        check("rst_vs_start_idle", 32'(busy), 32'(0));
        check("rst_vs_start_q", 32'(q), 32'(0));
        run_conv(24'h000123, 1'b0);

        // Reset in the middle of a conversion.
        dig   = 24'h777777;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_busy_before", 32'(busy), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_q", 32'(q), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) seen_done++;
        end
        check("mid_rst_no_done", 32'(seen_done), 32'(0));
        run_conv(24'h777777, 1'b0);

        // Randomized conversions against the decimal model.
        for (int t = 0; t < 40; t++) begin
            run_conv(rand_digits(1'b1), ($urandom % 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
